fir_mac_engine: RTL

Time-multiplexed serial FIR filter engine that reads the coefficient ROM (`coef`) as its initiator. It drives the ROM address, absorbs the ROM's one-cycle registered read latency, and keeps the last `Order+1` input samples in a circular delay line. For each accepted sample it performs `Order+1` multiply-accumulates and emits one rounded, saturated output. It sits between the audio sample source and the downstream acoustic processing chain.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_sample_buf.sv | 42 ++++
 rtl/fir_mac_engine.sv | 74 +++++++
 3 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, FSM state type and output saturation for the serial FIR engine.
package fir_pkg;
    localparam int ORDER      = 39;
    localparam int ORDER_MSB  = 5;
    localparam int FILTER_MSB = 15;
    localparam int ACC_W      = 38;
    localparam int Q_SHIFT    = 15;

    localparam logic signed [ACC_W-1:0] RND    = ACC_W'(2 ** (Q_SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** FILTER_MSB) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** FILTER_MSB));

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fir_state_t;

    // Round half-up out of Q1.15, then clamp to the sample range.
    function automatic logic signed [FILTER_MSB:0] saturate(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = (acc + RND) >>> Q_SHIFT;
        return (r > SAT_HI) ? SAT_HI[FILTER_MSB:0] : (r < SAT_LO) ? SAT_LO[FILTER_MSB:0] : r[FILTER_MSB:0];
    endfunction
endpackage

// File: rtl/fir_sample_buf.sv
// fir_sample_buf: circular delay line of the last Order+1 samples with a tap-indexed registered read.
module fir_sample_buf
    import fir_pkg::*;
#(
    parameter int Order_MSB  = ORDER_MSB,
    parameter int Filter_MSB = FILTER_MSB,
    parameter int Order      = ORDER
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       we,
    input  logic signed [Filter_MSB:0] din,
    input  logic                       rd_en,
    input  logic        [Order_MSB:0]  tap,
    output logic signed [Filter_MSB:0] dout
);
    localparam logic [Order_MSB:0] LAST  = (Order_MSB + 1)'(Order);
    localparam logic [Order_MSB:0] DEPTH = (Order_MSB + 1)'(Order + 1);

    logic signed [Filter_MSB:0] mem [Order + 1];
    logic [Order_MSB:0] wr_ptr, newest, ridx;

    // Tap 0 is the most recent write; older taps wrap back past slot 0.
    always_comb begin
        newest = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
        ridx   = newest - tap + ((newest < tap) ? DEPTH : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= Order; i++) mem[i] <= '0;
            wr_ptr <= '0;
            dout   <= '0;
        end else begin
            if (we) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) dout <= mem[ridx];
        end
    end
endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: time-multiplexed FIR, one MAC per cycle against an external ROM with
// one-cycle registered read latency; emits one rounded, saturated result per accepted sample.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int Order_MSB  = ORDER_MSB,
    parameter int Filter_MSB = FILTER_MSB,
    parameter int Order      = ORDER
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic signed [Filter_MSB:0] sample_in,
    input  logic                       sample_valid,
    output logic                       ready,
    output logic        [Order_MSB:0]  coef_addr,
    input  logic signed [Filter_MSB:0] coef_bits,
    output logic signed [Filter_MSB:0] filt_out,
    output logic                       filt_valid,
    output logic                       overrun
);
    localparam logic [Order_MSB:0] LAST = (Order_MSB + 1)'(Order);

    fir_state_t state, nxt;
    logic [Order_MSB:0] k;
    logic signed [Filter_MSB:0] sample_reg;
    logic signed [2*Filter_MSB+1:0] prod;
    logic signed [ACC_W-1:0] acc;
    logic mac;

    fir_sample_buf #(
        .Order_MSB (Order_MSB),
        .Filter_MSB(Filter_MSB),
        .Order     (Order)
    ) u_buf (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (ready && sample_valid),
        .din    (sample_in),
        .rd_en  (state == RUN),
        .tap    (k),
        .dout   (sample_reg)
    );

    always_comb begin
        nxt = state;
        nxt = (state == IDLE)  ? (sample_valid ? RUN : IDLE) :
              (state == RUN)   ? ((k == LAST) ? DRAIN : RUN) :
              (state == DRAIN) ? DONE : IDLE;
    end

    assign ready     = state == IDLE;
    assign coef_addr = (state == RUN) ? k : '0;
    assign prod      = coef_bits * sample_reg;
    // ROM data and sample_reg for tap k both land one edge after k is issued.
    assign mac       = ((state == RUN) && (k != '0)) || (state == DRAIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            k          <= '0;
            acc        <= '0;
            filt_out   <= '0;
            filt_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= nxt;
            k          <= (state == RUN) ? k + 1'b1 : '0;
            acc        <= (state == IDLE) ? '0 : mac ? acc + ACC_W'(prod) : acc;
            filt_valid <= state == DONE;
            overrun    <= sample_valid && (state != IDLE);
            if (state == DONE) filt_out <= saturate(acc);
        end
    end
endmodule
